// File: rtl/cp0_exc_sequencer_pkg.sv
// rtl/cp0_exc_sequencer_pkg.sv - CP0 addresses, ExcCodes and sequencer state encodings
package cp0_exc_sequencer_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
    localparam logic [4:0]  A_BADVADDR_DEF = 5'd8;
    localparam logic [4:0]  A_STATUS_DEF   = 5'd12;
    localparam logic [4:0]  A_CAUSE_DEF    = 5'd13;
    localparam logic [4:0]  A_EPC_DEF      = 5'd14;

    localparam int          EXL_BIT        = 1;
    localparam logic [4:0]  EXC_ADEL       = 5'd4;
    localparam logic [4:0]  EXC_ADES       = 5'd5;

    localparam logic [2:0]  S_IDLE         = 3'd0;
    localparam logic [2:0]  S_W_BADV       = 3'd1;
    localparam logic [2:0]  S_W_EPC        = 3'd2;
    localparam logic [2:0]  S_W_CAUSE      = 3'd3;
    localparam logic [2:0]  S_W_STATUS     = 3'd4;
    localparam logic [2:0]  S_E_STATUS     = 3'd5;
    localparam logic [2:0]  S_REDIR        = 3'd6;

    // A fault in a delay slot restarts at the branch, one word earlier.
    function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_exc_sequencer.sv
// rtl/cp0_exc_sequencer.sv - single CP0 write port: MTC0 merge plus exception/ERET update sequences
module cp0_exc_sequencer
    import cp0_exc_sequencer_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [4:0]  A_BADVADDR = A_BADVADDR_DEF,
    parameter logic [4:0]  A_STATUS   = A_STATUS_DEF,
    parameter logic [4:0]  A_CAUSE    = A_CAUSE_DEF,
    parameter logic [4:0]  A_EPC      = A_EPC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_en_i,
    input  logic [4:0]  mtc0_addr_i,
    input  logic [31:0] mtc0_data_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_bd_i,
    input  logic [31:0] exc_badvaddr_i,
    input  logic        eret_valid_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        exc_ack_o,
    output logic        cp_write_en_o,
    output logic [4:0]  cp_write_addr_o,
    output logic [31:0] cp_write_data_o,
    output logic        busy_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [4:0]  r_code;
    logic        r_bd;
    logic        r_exl;
    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [31:0] r_status_base;
    logic [31:0] r_redirect_pc;

    logic        w_idle;
    logic        w_accept_exc;
    logic        w_accept_eret;
    logic [31:0] w_status_base;
    logic        w_exl_in;
    logic        w_adex_in;
    logic        w_cause_bd;
    logic        w_unused;

    assign w_idle        = (r_state == S_IDLE);
    assign w_accept_exc  = w_idle && exc_valid_i;
    assign w_accept_eret = w_idle && !exc_valid_i && eret_valid_i;

    // A same-cycle MTC0 to Status is older than the exception, so it forms the base.
    assign w_status_base = (mtc0_en_i && mtc0_addr_i == A_STATUS) ? mtc0_data_i : status_i;
    assign w_exl_in      = w_status_base[EXL_BIT];
    assign w_adex_in     = (exc_code_i == EXC_ADEL) || (exc_code_i == EXC_ADES);
    assign w_cause_bd    = r_exl ? cause_i[31] : r_bd;
    assign w_unused      = ^cause_i[6:2];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_exc)
                    w_next_state = w_adex_in ? S_W_BADV : (w_exl_in ? S_W_CAUSE : S_W_EPC);
                else if (w_accept_eret)
                    w_next_state = S_E_STATUS;
            end
            S_W_BADV:   w_next_state = r_exl ? S_W_CAUSE : S_W_EPC;
            S_W_EPC:    w_next_state = S_W_CAUSE;
            S_W_CAUSE:  w_next_state = S_W_STATUS;
            S_W_STATUS: w_next_state = S_REDIR;
            S_E_STATUS: w_next_state = S_REDIR;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_code        <= '0;
            r_bd          <= 1'b0;
            r_exl         <= 1'b0;
            r_badvaddr    <= '0;
            r_epc         <= '0;
            r_status_base <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept_exc) begin
                r_code        <= exc_code_i;
                r_bd          <= exc_bd_i;
                r_exl         <= w_exl_in;
                r_badvaddr    <= exc_badvaddr_i;
                r_epc         <= exc_epc(exc_pc_i, exc_bd_i);
                r_status_base <= w_status_base;
            end
            if (r_state == S_W_STATUS)
                r_redirect_pc <= EXC_VECTOR;
            else if (r_state == S_E_STATUS)
                r_redirect_pc <= epc_i;
        end
    end

    always_comb begin
        cp_write_en_o   = 1'b0;
        cp_write_addr_o = '0;
        cp_write_data_o = '0;
        case (r_state)
            S_IDLE: begin
                if (mtc0_en_i && rst_n) begin
                    cp_write_en_o   = 1'b1;
                    cp_write_addr_o = mtc0_addr_i;
                    cp_write_data_o = mtc0_data_i;
                end
            end
            S_W_BADV: begin
                cp_write_en_o   = 1'b1;
                cp_write_addr_o = A_BADVADDR;
                cp_write_data_o = r_badvaddr;
            end
            S_W_EPC: begin
                cp_write_en_o   = 1'b1;
                cp_write_addr_o = A_EPC;
                cp_write_data_o = r_epc;
            end
            S_W_CAUSE: begin
                cp_write_en_o   = 1'b1;
                cp_write_addr_o = A_CAUSE;
                cp_write_data_o = {w_cause_bd, cause_i[30:7], r_code, cause_i[1:0]};
            end
            S_W_STATUS: begin
                cp_write_en_o   = 1'b1;
                cp_write_addr_o = A_STATUS;
                cp_write_data_o = r_status_base | 32'h2;
            end
            S_E_STATUS: begin
                cp_write_en_o   = 1'b1;
                cp_write_addr_o = A_STATUS;
                cp_write_data_o = status_i & ~32'h2;
            end
            default: begin
                cp_write_en_o   = 1'b0;
            end
        endcase
    end

    assign exc_ack_o        = rst_n && (w_accept_exc || w_accept_eret);
    assign busy_o           = !w_idle;
    assign flush_o          = (r_state == S_REDIR);
    assign redirect_valid_o = (r_state == S_REDIR);
    assign redirect_pc_o    = r_redirect_pc;

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// tb/tb_cp0_exc_sequencer.sv - scoreboard bench for the CP0 exception sequencer
module tb_cp0_exc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        mtc0_en_i;
    logic [4:0]  mtc0_addr_i;
    logic [31:0] mtc0_data_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic [31:0] exc_pc_i;
    logic        exc_bd_i;
    logic [31:0] exc_badvaddr_i;
    logic        eret_valid_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        exc_ack_o;
    logic        cp_write_en_o;
    logic [4:0]  cp_write_addr_o;
    logic [31:0] cp_write_data_o;
    logic        busy_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    cp0_exc_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mtc0_en_i        (mtc0_en_i),
        .mtc0_addr_i      (mtc0_addr_i),
        .mtc0_data_i      (mtc0_data_i),
        .exc_valid_i      (exc_valid_i),
        .exc_code_i       (exc_code_i),
        .exc_pc_i         (exc_pc_i),
        .exc_bd_i         (exc_bd_i),
        .exc_badvaddr_i   (exc_badvaddr_i),
        .eret_valid_i     (eret_valid_i),
        .status_i         (status_i),
        .cause_i          (cause_i),
        .epc_i            (epc_i),
        .exc_ack_o        (exc_ack_o),
        .cp_write_en_o    (cp_write_en_o),
        .cp_write_addr_o  (cp_write_addr_o),
        .cp_write_data_o  (cp_write_data_o),
        .busy_o           (busy_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    typedef struct {
        bit          redir;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [4:0] addr, input logic [31:0] data, input int c);
        exp_t e;
        e.redir = 1'b0; e.addr = addr; e.data = data; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_redir(input logic [31:0] pc, input int c);
        exp_t e;
        e.redir = 1'b1; e.addr = 5'd0; e.data = pc; e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: every write or redirect the DUT presents must match the next scoreboard entry.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && (cp_write_en_o || redirect_valid_o)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got wr=%0b addr=%0d data=%h redir=%0b, expected none",
                         cp_write_en_o, cp_write_addr_o, cp_write_data_o, redirect_valid_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_kind_redir", {31'd0, redirect_valid_o}, {31'd0, e.redir});
                check("mon_cycle", cyc, e.cyc);
                if (e.redir) begin
                    check("mon_redirect_pc", redirect_pc_o, e.data);
                    check("mon_flush", {31'd0, flush_o}, 32'd1);
                end else begin
                    check("mon_write_addr", {27'd0, cp_write_addr_o}, {27'd0, e.addr});
                    check("mon_write_data", cp_write_data_o, e.data);
                end
            end
        end
    end

    task automatic start_req(input logic exc, input logic eret, input logic [4:0] code,
                             input logic [31:0] pc, input logic bd, input logic [31:0] badv,
                             input logic [31:0] status, input logic [31:0] cause, input logic [31:0] epc,
                             input logic m_en, input logic [4:0] m_addr, input logic [31:0] m_data,
                             output int t);
        @(posedge clk); #1;
        exc_valid_i = exc; eret_valid_i = eret; exc_code_i = code; exc_pc_i = pc;
        exc_bd_i = bd; exc_badvaddr_i = badv; status_i = status; cause_i = cause; epc_i = epc;
        mtc0_en_i = m_en; mtc0_addr_i = m_addr; mtc0_data_i = m_data;
        t = cyc + 1;
    endtask

    task automatic finish_req(input string name);
        @(negedge clk); #1;
        check(name, {31'd0, exc_ack_o}, 32'd1);
        @(posedge clk); #1;
        exc_valid_i = 1'b0; eret_valid_i = 1'b0; mtc0_en_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy_o || sb.size() != 0) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (busy_o || sb.size() != 0) begin
            errors++;
            $display("FAIL %s: got busy=%0b pending=%0d, expected idle and drained", name, busy_o, sb.size());
        end
    endtask

    int t;

    initial begin
        rst_n = 1'b0;
        mtc0_en_i = 1'b1; mtc0_addr_i = 5'd12; mtc0_data_i = 32'hFFFF_FFFF;
        exc_valid_i = 1'b1; exc_code_i = 5'd0; exc_pc_i = '0; exc_bd_i = 1'b0;
        exc_badvaddr_i = '0; eret_valid_i = 1'b0; status_i = '0; cause_i = '0; epc_i = '0;

        // Reset state, with requests and MTC0 asserted: everything must stay low.
        repeat (2) @(negedge clk);
        check("rst_write_en", {31'd0, cp_write_en_o}, 32'd0);
        check("rst_write_data", cp_write_data_o, 32'd0);
        check("rst_ack", {31'd0, exc_ack_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_redirect", {31'd0, redirect_valid_o}, 32'd0);
        check("rst_redirect_pc", redirect_pc_o, 32'd0);
        @(posedge clk); #1;
        mtc0_en_i = 1'b0; exc_valid_i = 1'b0;
        rst_n = 1'b1;

        // Plain MTC0 in IDLE: same-cycle write.
        @(posedge clk); #1;
        mtc0_en_i = 1'b1; mtc0_addr_i = 5'd11; mtc0_data_i = 32'h0000_1234;
        push_wr(5'd11, 32'h0000_1234, cyc + 1);
        @(negedge clk); #1;
        check("mtc0_no_ack", {31'd0, exc_ack_o}, 32'd0);
        @(posedge clk); #1;
        mtc0_en_i = 1'b0;
        wait_idle("mtc0_idle");

        // Overflow, EXL clear: EPC, Cause, Status, redirect at T+4.
        start_req(1, 0, 5'd12, 32'h8000_1000, 0, 32'h0, 32'h0000_FF01, 32'h0, 32'h0, 0, 5'd0, 32'h0, t);
        push_wr(5'd14, 32'h8000_1000, t + 1);
        push_wr(5'd13, 32'h0000_0030, t + 2);
        push_wr(5'd12, 32'h0000_FF03, t + 3);
        push_redir(32'hBFC0_0380, t + 4);
        finish_req("ov_ack");
        wait_idle("ov_idle");

        // AdEL in a delay slot: BadVAddr first, EPC backed up, BD set, live IP kept.
        start_req(1, 0, 5'd4, 32'h8000_2004, 1, 32'h0000_0003, 32'h0000_FF01, 32'h0000_0400, 32'h0, 0, 5'd0, 32'h0, t);
        push_wr(5'd8,  32'h0000_0003, t + 1);
        push_wr(5'd14, 32'h8000_2000, t + 2);
        push_wr(5'd13, 32'h8000_0410, t + 3);
        push_wr(5'd12, 32'h0000_FF03, t + 4);
        push_redir(32'hBFC0_0380, t + 5);
        finish_req("adel_ack");
        wait_idle("adel_idle");

        // EXL already set: no EPC, BD frozen at live Cause[31] (0) despite bd=1.
        start_req(1, 0, 5'd10, 32'h8000_5004, 1, 32'h0, 32'h0000_0003, 32'h0, 32'h0, 0, 5'd0, 32'h0, t);
        push_wr(5'd13, 32'h0000_0028, t + 1);
        push_wr(5'd12, 32'h0000_0003, t + 2);
        push_redir(32'hBFC0_0380, t + 3);
        finish_req("exl_ack");
        wait_idle("exl_idle");

        // Same-cycle MTC0 Status clears EXL for the exception that follows it.
        start_req(1, 0, 5'd8, 32'h8000_4000, 0, 32'h0, 32'h0000_0003, 32'h0, 32'h0, 1, 5'd12, 32'h0000_AA01, t);
        push_wr(5'd12, 32'h0000_AA01, t);
        push_wr(5'd14, 32'h8000_4000, t + 1);
        push_wr(5'd13, 32'h0000_0020, t + 2);
        push_wr(5'd12, 32'h0000_AA03, t + 3);
        push_redir(32'hBFC0_0380, t + 4);
        finish_req("fwd_ack");
        wait_idle("fwd_idle");

        // ERET: clear EXL, redirect to EPC at T+2; an MTC0 while busy is dropped.
        start_req(0, 1, 5'd0, 32'h0, 0, 32'h0, 32'h0000_0003, 32'h0, 32'h8000_3000, 0, 5'd0, 32'h0, t);
        push_wr(5'd12, 32'h0000_0001, t + 1);
        push_redir(32'h8000_3000, t + 2);
        finish_req("eret_ack");
        mtc0_en_i = 1'b1; mtc0_addr_i = 5'd9; mtc0_data_i = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        check("busy_mtc0_addr", {27'd0, cp_write_addr_o}, 32'd12);
        check("busy_mtc0_data", cp_write_data_o, 32'h0000_0001);
        @(posedge clk); #1;
        mtc0_en_i = 1'b0;
        wait_idle("eret_idle");

        // Reset asserted during W_CAUSE: outputs drop at once, sequence is abandoned.
        start_req(1, 0, 5'd12, 32'h8000_6000, 0, 32'h0, 32'h0000_0001, 32'h0, 32'h0, 0, 5'd0, 32'h0, t);
        push_wr(5'd14, 32'h8000_6000, t + 1);
        finish_req("rstmid_ack");
        @(posedge clk); #1;
        check("rstmid_in_cause", {31'd0, cp_write_en_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_write_en", {31'd0, cp_write_en_o}, 32'd0);
        check("rstmid_busy", {31'd0, busy_o}, 32'd0);
        check("rstmid_redirect", {31'd0, redirect_valid_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            check("post_rst_busy", {31'd0, busy_o}, 32'd0);
            check("post_rst_write_en", {31'd0, cp_write_en_o}, 32'd0);
        end
        check("post_rst_pending", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
